// File: rtl/svsg_counter.sv
// svsg_counter: seven-segment BCD digit counter with a Wishbone control slave.
//
// A prescaled decimal digit (0-9, up or down) is encoded onto io_out as
// segments {a,b,c,d,e,f,g,dp}, bit7 = a, active-high. It runs out of reset.
//
// Ports:
//   wb_clk_i   in   system clock, rising edge
//   wb_rst_i   in   synchronous active-high reset
//   wbs_cyc_i  in   Wishbone cycle
//   wbs_stb_i  in   Wishbone strobe
//   wbs_we_i   in   write enable
//   wbs_sel_i  in   [3:0] byte selects
//   wbs_adr_i  in   [31:0] byte address
//   wbs_dat_i  in   [31:0] write data
//   wbs_ack_o  out  one-cycle acknowledge
//   wbs_dat_o  out  [31:0] read data, valid with ack, 0 otherwise
//   io_out     out  [7:0] segment pattern
//   io_oeb     out  [7:0] output enables, active-low, constant 0
//
// Registers (BASE_ADR + offset):
//   +0x0 CTRL     [0] en (reset 1), [1] down (reset 0), [2] clr (write-1 pulse, reads 0)
//   +0x4 PRESCALE [23:0], reset DEFAULT_PRESCALE
//   +0x8 STATUS   [3:0] digit, [4] dp toggle (read-only)
//
// Configuration macro: SVSG_DP_BLINK_EN -- when defined, the dp segment toggles
// on every digit wrap and is reported in STATUS[4]; otherwise dp is held at 0.

module svsg_counter #(
    parameter logic [31:0] BASE_ADR         = 32'h3000_0000,
    parameter logic [23:0] DEFAULT_PRESCALE = 24'd1000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [7:0]  io_out,
    output logic [7:0]  io_oeb
);

    typedef enum logic [1:0] {
        REG_CTRL     = 2'd0,
        REG_PRESCALE = 2'd1,
        REG_STATUS   = 2'd2,
        REG_NONE     = 2'd3
    } reg_off_t;

    logic        r_req_d;
    logic        r_ack;
    logic [31:0] r_dat;
    logic        r_en;
    logic        r_down;
    logic [23:0] r_psc;
    logic [23:0] r_pcnt;
    logic [3:0]  r_digit;
    logic [7:0]  r_io;

    logic        w_req;
    logic        w_acc;
    logic        w_wr;
    reg_off_t    w_off;
    logic        w_ctrl_wr;
    logic        w_clr;
    logic        w_psc_wr;
    logic [23:0] w_plast;
    logic        w_tick;
    logic        w_wrap;
    logic [3:0]  w_digit_nxt;
    logic [6:0]  w_seg;
    logic        w_dp;
    logic [31:0] w_rdata;
    logic        w_unused;

    // A request is accepted only on its first cycle; a strobe held through
    // the ack cycle (or longer) must drop before another access is taken.
    assign w_req     = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADR[31:4]);
    assign w_acc     = w_req & ~r_req_d;
    assign w_wr      = w_acc & wbs_we_i;
    assign w_off     = reg_off_t'(wbs_adr_i[3:2]);
    assign w_ctrl_wr = w_wr & (w_off == REG_CTRL) & wbs_sel_i[0];
    assign w_clr     = w_ctrl_wr & wbs_dat_i[2];
    assign w_psc_wr  = w_wr & (w_off == REG_PRESCALE) & (|wbs_sel_i[2:0]);

    // PRESCALE of 0 behaves as 1: the period end is then pcnt == 0.
    assign w_plast = (r_psc <= 24'd1) ? 24'd0 : (r_psc - 24'd1);
    assign w_tick  = r_en & (r_pcnt == w_plast);

    always_comb begin
        w_wrap      = 1'b0;
        w_digit_nxt = r_digit;
        if (r_down) begin
            if (r_digit == 4'd0) begin
                w_digit_nxt = 4'd9;
                w_wrap      = 1'b1;
            end else begin
                w_digit_nxt = r_digit - 4'd1;
            end
        end else begin
            if (r_digit >= 4'd9) begin
                w_digit_nxt = 4'd0;
                w_wrap      = 1'b1;
            end else begin
                w_digit_nxt = r_digit + 4'd1;
            end
        end
    end

    always_comb begin
        w_seg = 7'b0000000;
        case (r_digit)
            4'd0:    w_seg = 7'b1111110;
            4'd1:    w_seg = 7'b0110000;
            4'd2:    w_seg = 7'b1101101;
            4'd3:    w_seg = 7'b1111001;
            4'd4:    w_seg = 7'b0110011;
            4'd5:    w_seg = 7'b1011011;
            4'd6:    w_seg = 7'b1011111;
            4'd7:    w_seg = 7'b1110000;
            4'd8:    w_seg = 7'b1111111;
            4'd9:    w_seg = 7'b1111011;
            default: w_seg = 7'b0000000;
        endcase
    end

`ifdef SVSG_DP_BLINK_EN
    logic r_dp;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_dp <= 1'b0;
        end else if (w_clr) begin
            r_dp <= 1'b0;
        end else if (!w_psc_wr && w_tick && w_wrap) begin
            r_dp <= ~r_dp;
        end
    end

    assign w_dp = r_dp;
`else
    assign w_dp = 1'b0;
`endif

    always_comb begin
        w_rdata = '0;
        case (w_off)
            REG_CTRL:     w_rdata = {30'd0, r_down, r_en};
            REG_PRESCALE: w_rdata = {8'd0, r_psc};
            REG_STATUS:   w_rdata = {27'd0, w_dp, r_digit};
            default:      w_rdata = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_req_d <= 1'b0;
            r_ack   <= 1'b0;
            r_dat   <= '0;
            r_en    <= 1'b1;
            r_down  <= 1'b0;
            r_psc   <= DEFAULT_PRESCALE;
            r_pcnt  <= '0;
            r_digit <= '0;
            r_io    <= 8'hFC;
        end else begin
            r_req_d <= w_req;
            r_ack   <= w_acc;
            r_dat   <= (w_acc && !wbs_we_i) ? w_rdata : '0;

            if (w_ctrl_wr) begin
                r_en   <= wbs_dat_i[0];
                r_down <= wbs_dat_i[1];
            end

            if (w_wr && (w_off == REG_PRESCALE)) begin
                for (int unsigned b = 0; b < 3; b++) begin
                    if (wbs_sel_i[b]) begin
                        r_psc[b*8 +: 8] <= wbs_dat_i[b*8 +: 8];
                    end
                end
            end

            // clr beats a PRESCALE write, which beats the tick; both
            // restart the prescaler and swallow a coincident tick.
            if (w_clr) begin
                r_pcnt  <= '0;
                r_digit <= '0;
            end else if (w_psc_wr) begin
                r_pcnt  <= '0;
            end else if (r_en) begin
                if (w_tick) begin
                    r_pcnt  <= '0;
                    r_digit <= w_digit_nxt;
                end else begin
                    r_pcnt  <= r_pcnt + 24'd1;
                end
            end

            r_io <= {w_seg, w_dp};
        end
    end

    assign w_unused  = ^{wbs_adr_i[1:0], wbs_dat_i[31:24], wbs_sel_i[3]};
    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_dat;
    assign io_out    = r_io;
    assign io_oeb    = 8'h00;

endmodule

// File: tb/tb_svsg_counter.sv
// Self-checking bench for svsg_counter: directed scenarios followed by random
// bus traffic, all checked cycle by cycle against a behavioural model.

module tb_svsg_counter;

    localparam logic [31:0] BASE = 32'h3000_0000;
`ifdef SVSG_DP_BLINK_EN
    localparam bit DPX = 1'b1;
`else
    localparam bit DPX = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
    logic        ack;
    logic [31:0] dat_o;
    logic [7:0]  io_out;
    logic [7:0]  io_oeb;

    always #5 clk = ~clk;

    svsg_counter #(
        .BASE_ADR         (BASE),
        .DEFAULT_PRESCALE (24'd1000)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wbs_cyc_i (cyc),
        .wbs_stb_i (stb),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_adr_i (adr),
        .wbs_dat_i (dat),
        .wbs_ack_o (ack),
        .wbs_dat_o (dat_o),
        .io_out    (io_out),
        .io_oeb    (io_oeb)
    );

    // Reference model: digit as an integer 0..9, elapsed enabled cycles in
    // the current prescale period, and the wrap parity for dp.
    logic [7:0]  SEG [10] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66,
                              8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6};
    int          m_digit;
    int          m_cnt;
    bit          m_en;
    bit          m_down;
    bit          m_dp;
    logic [23:0] m_psc;
    logic [7:0]  m_io;
    bit          m_prev_req;
    bit          exp_ack;
    logic [31:0] exp_dat;
    logic [31:0] rd_last;
    int          ack_seen;
    int          n_chk = 0;
    int          n_err = 0;

    function automatic logic [7:0] enc(input int d, input bit dp);
        return SEG[d] | {7'd0, DPX & dp};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_digit    = 0;
        m_cnt      = 0;
        m_en       = 1'b1;
        m_down     = 1'b0;
        m_dp       = 1'b0;
        m_psc      = 24'd1000;
        m_io       = 8'hFC;
        m_prev_req = 1'b0;
    endtask

    // Advance one clock, update the model with what the bus presented at
    // that edge, then compare outputs 1 time unit later.
    task automatic step();
        bit req;
        bit acc;
        bit clr;
        bit pw;
        int off;
        int per;
        req = cyc && stb && (adr[31:4] == BASE[31:4]);
        acc = req && !m_prev_req;
        off = int'(adr[3:2]);
        @(posedge clk);
        if (rst) begin
            model_reset();
            exp_ack = 1'b0;
            exp_dat = '0;
        end else begin
            exp_ack = acc;
            exp_dat = '0;
            if (acc && !we) begin
                case (off)
                    0:       exp_dat = {30'd0, m_down, m_en};
                    1:       exp_dat = {8'd0, m_psc};
                    2:       exp_dat = {27'd0, DPX & m_dp, 4'(m_digit)};
                    default: exp_dat = '0;
                endcase
            end
            m_io = enc(m_digit, m_dp);
            per  = (m_psc == 24'd0) ? 1 : int'(m_psc);
            clr  = acc && we && off == 0 && sel[0] && dat[2];
            pw   = acc && we && off == 1 && (sel[2:0] != 3'b000);
            if (clr) begin
                m_digit = 0;
                m_cnt   = 0;
                m_dp    = 1'b0;
            end else if (pw) begin
                m_cnt = 0;
            end else if (m_en) begin
                m_cnt++;
                if (m_cnt == per) begin
                    m_cnt = 0;
                    if (m_down) begin
                        if (m_digit == 0) m_dp = ~m_dp;
                        m_digit = (m_digit + 9) % 10;
                    end else begin
                        if (m_digit == 9) m_dp = ~m_dp;
                        m_digit = (m_digit + 1) % 10;
                    end
                end
            end
            if (acc && we && off == 0 && sel[0]) begin
                m_en   = dat[0];
                m_down = dat[1];
            end
            if (acc && we && off == 1) begin
                for (int b = 0; b < 3; b++) begin
                    if (sel[b]) m_psc[b*8 +: 8] = dat[b*8 +: 8];
                end
            end
            m_prev_req = req;
        end
        #1;
        check("ack", {31'd0, ack}, {31'd0, exp_ack});
        check("dat_o", dat_o, exp_dat);
        check("io_out", {24'd0, io_out}, {24'd0, m_io});
        if (ack === 1'b1) begin
            rd_last = dat_o;
            ack_seen++;
        end
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; dat = d; sel = s;
        step();
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        step();
    endtask

    task automatic wb_read(input logic [31:0] a, input int hold, output logic [31:0] d);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a; sel = 4'hF;
        repeat (hold) step();
        cyc = 1'b0; stb = 1'b0;
        step();
        d = rd_last;
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] d;
        int          guard;
        int          op;

        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        sel = 4'h0; adr = '0; dat = '0; rd_last = '0; ack_seen = 0;
        model_reset();
        exp_ack = 1'b0;
        exp_dat = '0;

        // Reset state and free-running count at the default prescale.
        step();
        step();
        check("reset_io_out", {24'd0, io_out}, 32'h0000_00FC);
        check("reset_io_oeb", {24'd0, io_oeb}, 32'h0000_0000);
        rst = 1'b0;
        for (int n = 1; n <= 10001; n++) begin
            step();
            if (n == 1000)  check("io_at_1000", {24'd0, io_out}, 32'h0000_00FC);
            if (n == 1001)  check("io_at_1001", {24'd0, io_out}, 32'h0000_0060);
            if (n == 9001)  check("io_at_9001", {24'd0, io_out}, 32'h0000_00F6);
            if (n == 10001) check("io_at_10001", {24'd0, io_out}, {24'd0, 7'h7E, DPX});
        end

        // PRESCALE=0, down mode: digit steps every cycle.
        wb_write(BASE + 32'h4, 32'h0, 4'hF);
        wb_write(BASE + 32'h0, 32'h3, 4'hF);
        repeat (25) step();

        // P=4, clr lands on the edge where a tick is due.
        wb_write(BASE + 32'h4, 32'h4, 4'hF);
        step();
        step();
        wb_write(BASE + 32'h0, 32'h5, 4'hF);
        repeat (3) begin
            step();
            check("clr_hold_fc", {24'd0, io_out}, 32'h0000_00FC);
        end
        step();
        check("clr_first_change", {24'd0, io_out}, 32'h0000_0060);

        // Disable at digit 5, hold, then resume from the held prescale count.
        guard = 0;
        while (!(m_digit == 5 && m_cnt == 1) && guard < 200) begin
            step();
            guard++;
        end
        check("reach_digit5", {31'd0, guard < 200}, 32'd1);
        wb_write(BASE + 32'h0, 32'h0, 4'hF);
        repeat (100) begin
            step();
            check("hold_b6", {24'd0, io_out}, 32'h0000_00B6);
        end
        wb_read(BASE + 32'h8, 1, rd);
        check("status_held", rd, 32'h5);
        wb_write(BASE + 32'h0, 32'h1, 4'hF);
        step();
        check("resume_still_b6", {24'd0, io_out}, 32'h0000_00B6);
        step();
        check("resume_be", {24'd0, io_out}, 32'h0000_00BE);

        // Unmapped offset and held strobe.
        wb_read(BASE + 32'hC, 1, rd);
        check("read_0xC", rd, 32'h0);
        wb_write(BASE + 32'hC, 32'hFFFF_FFFF, 4'hF);
        wb_read(BASE + 32'h0, 1, rd);
        check("ctrl_after_0xC", rd, 32'h1);
        wb_read(BASE + 32'h4, 1, rd);
        check("psc_after_0xC", rd, 32'h4);
        ack_seen = 0;
        wb_read(BASE + 32'h8, 3, rd);
        check("held_read_acks", ack_seen, 32'd1);

        // Reset mid-read at digit 7.
        guard = 0;
        while (m_digit != 7 && guard < 200) begin
            step();
            guard++;
        end
        check("reach_digit7", {31'd0, guard < 200}, 32'd1);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h8; sel = 4'hF;
        rst = 1'b1;
        step();
        check("rst_mid_ack", {31'd0, ack}, 32'd0);
        check("rst_mid_io", {24'd0, io_out}, 32'h0000_00FC);
        rst = 1'b0; cyc = 1'b0; stb = 1'b0;
        step();
        wb_read(BASE + 32'h4, 1, rd);
        check("rst_psc_default", rd, 32'd1000);

        // Random traffic against the model.
        wb_write(BASE + 32'h4, 32'h3, 4'hF);
        for (int i = 0; i < 400; i++) begin
            op = $urandom_range(0, 6);
            case (op)
                0, 1: repeat ($urandom_range(1, 4)) step();
                2: begin
                    d = 32'($urandom_range(0, 7));
                    if ($urandom_range(0, 3) != 0) d[2] = 1'b0;
                    if ($urandom_range(0, 2) != 0) d[0] = 1'b1;
                    wb_write(BASE, d, 4'($urandom_range(0, 15)));
                end
                3: wb_write(BASE + 32'h4, {8'hA5, 16'h0000, 8'($urandom_range(0, 5))},
                            4'($urandom_range(0, 15)));
                4: wb_read(BASE + 32'(4 * $urandom_range(0, 3)), $urandom_range(1, 3), rd);
                5: wb_write(BASE + 32'h8, $urandom, 4'hF);
                default: wb_read(32'h3000_0010, 1, rd);
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/svsg_counter.md
# svsg_counter

Seven-segment BCD counter for the Caravel user project area: a prescaled decimal digit counter (0–9, up or down) whose encoded segment pattern drives `mprj_io[7:0]` through `io_out[7:0]`. It is the stage directly upstream of the pads that the io_ports bench observes. It runs out of reset with no firmware action, and exposes a small Wishbone slave for enable, direction, clear and prescale control.

## Interface
- `BASE_ADR`, 32'h3000_0000, Wishbone base address; registers at +0x0, +0x4, +0x8
- `DEFAULT_PRESCALE`, 24'd1000, prescale reload value after reset
- `wb_clk_i`  in  1  system clock, all logic on rising edge
- `wb_rst_i`  in  1  reset, synchronous, active-high
- `wbs_cyc_i`  in  1  Wishbone cycle
- `wbs_stb_i`  in  1  Wishbone strobe
- `wbs_we_i`  in  1  write enable
- `wbs_sel_i`  in  4  byte selects; writes honour selected bytes only
- `wbs_adr_i`  in  32  byte address
- `wbs_dat_i`  in  32  write data
- `wbs_ack_o`  out  1  acknowledge, one-cycle pulse
- `wbs_dat_o`  out  32  read data, valid with ack, 0 otherwise
- `io_out`  out  8  segments {a,b,c,d,e,f,g,dp}, bit7 = a, active-high
- `io_oeb`  out  8  output enables, active-low; constant 8'h00

## Operation
- Registers:
  - CTRL (+0x0): [0] `en`, reset 1; [1] `down`, reset 0; [2] `clr`, write-1 pulse, reads 0.
  - PRESCALE (+0x4): [23:0], reset DEFAULT_PRESCALE.
  - STATUS (+0x8, read-only): [3:0] digit, [4] dp toggle, [31:5] 0.
- Address match is `wbs_adr_i[31:4] == BASE_ADR[31:4]`, with the register selected by [3:2]. Unmapped offsets are acked, read 0, and ignore writes.
- Prescaler is a 24-bit `pcnt`. When `en` is set it counts 0..P-1, where P = max(PRESCALE, 1). At P-1 it generates `tick` and returns to 0. When `en` is clear, `pcnt` and digit hold.
- On `tick`:
  - Up mode: digit goes 0→1→…→9→0.
  - Down mode: digit goes 9→8→…→0→9.
  - Digit is 4-bit and never leaves 0–9.
- Encoding (dp excluded): 0=FC, 1=60, 2=DA, 3=F2, 4=66, 5=B6, 6=BE, 7=E0, 8=FE, 9=F6.
- Priority in one cycle: reset > `clr` > PRESCALE write > tick.
  - `clr` forces digit=0, `pcnt`=0 and dp toggle=0, and suppresses any coincident tick.
  - A PRESCALE write zeroes `pcnt` and suppresses a coincident tick.
- Toggling `down` mid-count does not reset `pcnt`; the next tick uses the new direction.

## Timing
- Reset values: `io_out`=8'hFC, `io_oeb`=8'h00, `wbs_ack_o`=0, `wbs_dat_o`=0, digit=0, `pcnt`=0.
- `wbs_ack_o` asserts on the cycle after `cyc&stb` is first seen and is held high for exactly one cycle. A strobe still high on the ack cycle is not re-accepted, so each access takes a minimum of 2 cycles.
- Register writes take effect on the ack edge.
- The digit updates on the edge where `tick` is high. `io_out` is registered and lags the digit by one cycle.
- From reset release with default P: digit=n at cycle n·P, and `io_out`=8'hF6 at cycle 9·P+1 (9001 for P=1000).
- P=0 or P=1: tick every enabled cycle, so the digit advances every cycle.
- Reset asserted mid-count returns all state to reset values on the next edge, regardless of any bus cycle in flight; no ack is issued for that access.

## Configuration
- `SVSG_DP_BLINK_EN` defined:
  - dp toggle flips on every wrap (9→0 up, 0→9 down).
  - `io_out[0]` = dp toggle.
  - STATUS[4] reflects the toggle.
- `SVSG_DP_BLINK_EN` undefined:
  - dp toggle is absent.
  - `io_out[0]` = 0 and STATUS[4] = 0.
  - Wrap behaviour is otherwise identical.

## Test plan
- Reset, no bus traffic, P=1000:
  - `io_out` = FC, then 60 at cycle 1001, …, F6 at cycle 9001.
  - `io_out` = FC at 10001; with macro, `io_out` = FD at 10001.
- Write PRESCALE=0, then CTRL=0x3 (down, en):
  - `io_out` sequence per cycle is FC, F6, FE, E0, …, 60, FC.
  - With macro, dp=1 from the first F6.
- With P=4, write CTRL=0x5 (en, clr) on the cycle a tick is due:
  - Digit stays 0, `pcnt` restarts, and the next change occurs 4 cycles after ack.
- Write CTRL=0x0 at digit 5:
  - `io_out` holds B6 for ≥100 cycles and STATUS reads 0x5.
  - Re-enable resumes from the held `pcnt`.
- Read +0xC and write +0xC:
  - Each acks in one cycle; the read returns 0 and state is unchanged.
  - A read held with `stb` high for 3 cycles yields exactly one ack pulse.
- Assert `wb_rst_i` for 1 cycle mid-read at digit 7:
  - Next cycle `io_out`=FC, `wbs_ack_o`=0, PRESCALE=1000.
